load_store_unit: RTL and testbench

Memory-access stage placed directly downstream of the ALU. It takes the ALU result as the effective address for LB/LW/SB/SW. It runs a single outstanding request/acknowledge transaction to data memory, formats byte lanes, and sign-extends load data. It stalls the upstream pipeline while a transaction is in flight and delivers load results to write-back.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_lane.sv | 37 +++
 rtl/load_store_unit.sv | 201 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: op codes, FSM states, byte-enable constants.
// The LSU_MISALIGN_TRAP_EN macro adds the FAULT state.
package lsu_pkg;

  localparam int unsigned LSU_DATA_W = 32;
  localparam int unsigned LSU_BE_W   = 4;

  typedef enum logic [1:0] {
    LSU_LB = 2'b00,
    LSU_LW = 2'b01,
    LSU_SB = 2'b10,
    LSU_SW = 2'b11
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_DONE  = 2'b10
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    ST_FAULT = 2'b11
`endif
  } lsu_state_e;

  localparam logic [LSU_BE_W-1:0] BE_WORD  = 4'b1111;
  localparam logic [LSU_BE_W-1:0] BE_BYTE0 = 4'b0001;

  function automatic logic op_is_store(input lsu_op_e op);
    return (op == LSU_SB) || (op == LSU_SW);
  endfunction

  function automatic logic op_is_byte(input lsu_op_e op);
    return (op == LSU_LB) || (op == LSU_SB);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte-lane steering: store enables/data replication and load byte extraction
// with sign extension.
module lsu_lane
  import lsu_pkg::*;
(
  input  lsu_op_e                 op_i,
  input  logic [1:0]              a_i,
  input  logic [LSU_DATA_W-1:0]   wdata_i,
  input  logic [LSU_DATA_W-1:0]   rdata_i,
  output logic [LSU_BE_W-1:0]     be_o,
  output logic [LSU_DATA_W-1:0]   wdata_o,
  output logic [LSU_DATA_W-1:0]   ld_data_o
);

  logic [7:0] rbyte;

  always_comb begin
    case (a_i)
      2'd0:    rbyte = rdata_i[7:0];
      2'd1:    rbyte = rdata_i[15:8];
      2'd2:    rbyte = rdata_i[23:16];
      default: rbyte = rdata_i[31:24];
    endcase
  end

  always_comb begin
    be_o      = BE_WORD;
    wdata_o   = wdata_i;
    ld_data_o = rdata_i;
    if (op_is_byte(op_i)) begin
      be_o      = BE_BYTE0 << a_i;
      wdata_o   = {4{wdata_i[7:0]}};
      ld_data_o = {{24{rbyte[7]}}, rbyte};
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one outstanding req/ack transaction, lane formatting, load write-back.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned LW/SW through a one-cycle FAULT state.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic [1:0]            ex_op,
  input  logic [ADDR_W-1:0]     ex_addr,
  input  logic [31:0]           ex_wdata,
  input  logic [RD_W-1:0]       ex_rd,
  output logic                  lsu_busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic                  wb_valid,
  output logic [RD_W-1:0]       wb_rd,
  output logic [31:0]           wb_data
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic                  fault
`endif
);

  lsu_state_e        state_q, state_d;
  lsu_op_e           op_q, op_d;
  logic [1:0]        a_q, a_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              busy_q, busy_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              wb_valid_q, wb_valid_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              fault_q, fault_d;
`endif

  lsu_op_e     lane_op;
  logic [1:0]  lane_a;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_ld;
  logic        trap_c;

  // Lane logic sees the incoming op while idle and the latched op during the transaction.
  assign lane_op = (state_q == ST_IDLE) ? lsu_op_e'(ex_op) : op_q;
  assign lane_a  = (state_q == ST_IDLE) ? ex_addr[1:0] : a_q;

  lsu_lane u_lane (
    .op_i      (lane_op),
    .a_i       (lane_a),
    .wdata_i   (ex_wdata),
    .rdata_i   (mem_rdata),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata),
    .ld_data_o (lane_ld)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_c = !op_is_byte(lsu_op_e'(ex_op)) && (ex_addr[1:0] != 2'b00);
`else
  assign trap_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= LSU_LB;
      a_q         <= 2'b00;
      rd_q        <= '0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      rd_q        <= rd_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
      fault_q     <= fault_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    rd_d        = rd_q;
    busy_d      = busy_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
    fault_d     = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          op_d   = lsu_op_e'(ex_op);
          a_d    = ex_addr[1:0];
          rd_d   = ex_rd;
          busy_d = 1'b1;
          if (trap_c) begin
`ifdef LSU_MISALIGN_TRAP_EN
            state_d = ST_FAULT;
            fault_d = 1'b1;
`endif
          end else begin
            state_d     = ST_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = ex_op[1];
            mem_addr_d  = {ex_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = lane_wdata;
            mem_be_d    = lane_be;
          end
        end
      end
      ST_REQ: begin
        // Request fields stay held until ack; a concurrent ex_valid is not looked at here.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (op_is_store(op_q)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d    = ST_DONE;
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = lane_ld;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
`ifdef LSU_MISALIGN_TRAP_EN
      ST_FAULT: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
`endif
      default: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign lsu_busy  = busy_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign fault     = fault_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed transactions, a per-cycle scoreboard
// against a transaction-level model, and literal expectations from hand calculation.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [1:0]  ex_op;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        lsu_busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        fault;
`endif

  int checks   = 0;
  int failures = 0;
  int wb_cnt   = 0;
  int w0;

  // Transaction currently expected at the memory port / write-back.
  logic [1:0]  cur_op    = 2'b00;
  logic [31:0] cur_addr  = '0;
  logic [31:0] cur_wdata = '0;
  logic [4:0]  cur_rd    = '0;
  logic [31:0] cur_rdata = '0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .RD_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex_valid  (ex_valid),
    .ex_op     (ex_op),
    .ex_addr   (ex_addr),
    .ex_wdata  (ex_wdata),
    .ex_rd     (ex_rd),
    .lsu_busy  (lsu_busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .fault     (fault)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: what the memory port and write-back must carry for a given op.
  function automatic logic [3:0] m_be(input logic [1:0] op, input logic [31:0] addr);
    if (op == 2'b01 || op == 2'b11) return 4'hF;
    return 4'(1 << addr[1:0]);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] op, input logic [31:0] d);
    if (op == 2'b10) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    return d;
  endfunction

  function automatic logic [31:0] m_ld(input logic [1:0] op, input logic [31:0] addr,
                                       input logic [31:0] rdata);
    int unsigned b;
    if (op == 2'b01) return rdata;
    b = (rdata >> (8 * addr[1:0])) & 32'hFF;
    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
  endfunction

  // Scoreboard: every cycle the memory request or write-back strobe is live.
  always @(negedge clk) begin
    if (mem_req) begin
      chk("req_busy",  32'(lsu_busy), 32'd1);
      chk("req_we",    32'(mem_we), 32'(cur_op[1]));
      chk("req_addr",  mem_addr, cur_addr & 32'hFFFF_FFFC);
      chk("req_be",    32'(mem_be), 32'(m_be(cur_op, cur_addr)));
      if (cur_op[1]) chk("req_wdata", mem_wdata, m_wdata(cur_op, cur_wdata));
    end
    if (wb_valid) begin
      wb_cnt++;
      chk("wb_is_load", 32'(cur_op[1]), 32'd0);
      chk("wb_rd",      32'(wb_rd), 32'(cur_rd));
      chk("wb_data",    wb_data, m_ld(cur_op, cur_addr, cur_rdata));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one cycle; returns in cycle 1 (first REQ cycle).
  task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd);
    step();
    ex_valid = 1'b1; ex_op = op; ex_addr = addr; ex_wdata = wd; ex_rd = rd;
    cur_op = op; cur_addr = addr; cur_wdata = wd; cur_rd = rd;
    step();
    ex_valid = 1'b0;
  endtask

  // Hold off ack for `stall` cycles, ack one cycle; returns in the cycle after the ack.
  task automatic ack(input int stall, input logic [31:0] rdata);
    repeat (stall) step();
    mem_ack = 1'b1; mem_rdata = rdata; cur_rdata = rdata;
    step();
    mem_ack = 1'b0; ex_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_op = 2'b00; ex_addr = '0; ex_wdata = '0; ex_rd = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) step();
    chk("rst_req",   32'(mem_req), 32'd0);
    chk("rst_busy",  32'(lsu_busy), 32'd0);
    chk("rst_we",    32'(mem_we), 32'd0);
    chk("rst_addr",  mem_addr, 32'd0);
    chk("rst_be",    32'(mem_be), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_wbv",   32'(wb_valid), 32'd0);
    chk("rst_wbrd",  32'(wb_rd), 32'd0);
    chk("rst_wbd",   wb_data, 32'd0);
    rst_n = 1'b1;

    // SW 0x100, ack on 2nd REQ cycle.
    issue(2'b11, 32'h100, 32'hDEAD_BEEF, 5'd0);
    chk("sw_req",   32'(mem_req), 32'd1);
    chk("sw_we",    32'(mem_we), 32'd1);
    chk("sw_be",    32'(mem_be), 32'hF);
    chk("sw_addr",  mem_addr, 32'h100);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sw_busy",  32'(lsu_busy), 32'd1);
    w0 = wb_cnt;
    ack(1, 32'h0);
    chk("sw_busy_fall", 32'(lsu_busy), 32'd0);
    chk("sw_req_fall",  32'(mem_req), 32'd0);
    step();
    chk("sw_no_wb", 32'(wb_cnt), 32'(w0));

    // LB 0x103 negative byte, immediate ack.
    issue(2'b00, 32'h103, 32'h0, 5'd7);
    chk("lb3_be", 32'(mem_be), 32'h8);
    chk("lb3_we", 32'(mem_we), 32'd0);
    ack(0, 32'h80FF_0000);
    chk("lb3_wbv",  32'(wb_valid), 32'd1);
    chk("lb3_rd",   32'(wb_rd), 32'd7);
    chk("lb3_data", wb_data, 32'hFFFF_FF80);
    chk("lb3_busy", 32'(lsu_busy), 32'd1);
    step();
    chk("lb3_wbv_pulse", 32'(wb_valid), 32'd0);
    chk("lb3_busy_fall", 32'(lsu_busy), 32'd0);

    // SB 0x202 replicates the byte into every lane.
    issue(2'b10, 32'h202, 32'h0000_00A5, 5'd0);
    chk("sb_addr",  mem_addr, 32'h200);
    chk("sb_be",    32'(mem_be), 32'h4);
    chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    ack(0, 32'h0);
    chk("sb_busy_fall", 32'(lsu_busy), 32'd0);

    // LB 0x101 positive byte, stalled ack.
    issue(2'b00, 32'h101, 32'h0, 5'd12);
    ack(2, 32'h1234_7F56);
    chk("lb1_data", wb_data, 32'h0000_007F);
    chk("lb1_rd",   32'(wb_rd), 32'd12);
    step();

    // LW aligned.
    issue(2'b01, 32'h104, 32'h0, 5'd31);
    chk("lw_be", 32'(mem_be), 32'hF);
    ack(0, 32'hCAFE_F00D);
    chk("lw_data", wb_data, 32'hCAFE_F00D);
    chk("lw_rd",   32'(wb_rd), 32'd31);
    step();

    // New op offered while the first is stalled 5 cycles, including on the ack cycle.
    issue(2'b11, 32'h500, 32'h1357_9BDF, 5'd0);
    ex_valid = 1'b1; ex_op = 2'b01; ex_addr = 32'h400;
    ack(5, 32'h0);
    chk("stall_busy_fall", 32'(lsu_busy), 32'd0);
    chk("stall_addr_hold", mem_addr, 32'h500);
    step();
    chk("stall_not_taken", 32'(mem_req), 32'd0);
    chk("stall_idle",      32'(lsu_busy), 32'd0);

    // Reset while a load waits in REQ; a late ack must be ignored.
    issue(2'b01, 32'h300, 32'h0, 5'd3);
    repeat (2) step();
    rst_n = 1'b0;
    step();
    chk("mrst_req",  32'(mem_req), 32'd0);
    chk("mrst_busy", 32'(lsu_busy), 32'd0);
    chk("mrst_wbd",  wb_data, 32'd0);
    rst_n = 1'b1;
    w0 = wb_cnt;
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    step();
    mem_ack = 1'b0;
    repeat (2) step();
    chk("mrst_no_wb",   32'(wb_cnt), 32'(w0));
    chk("mrst_no_req",  32'(mem_req), 32'd0);
    chk("mrst_no_busy", 32'(lsu_busy), 32'd0);

    // LW 0x102: misaligned word access.
`ifdef LSU_MISALIGN_TRAP_EN
    w0 = wb_cnt;
    issue(2'b01, 32'h102, 32'h0, 5'd9);
    chk("mis_fault",  32'(fault), 32'd1);
    chk("mis_no_req", 32'(mem_req), 32'd0);
    chk("mis_busy",   32'(lsu_busy), 32'd1);
    step();
    chk("mis_fault_pulse", 32'(fault), 32'd0);
    chk("mis_busy_fall",   32'(lsu_busy), 32'd0);
    chk("mis_no_req2",     32'(mem_req), 32'd0);
    chk("mis_no_wb",       32'(wb_cnt), 32'(w0));
`else
    issue(2'b01, 32'h102, 32'h0, 5'd9);
    chk("mis_addr", mem_addr, 32'h100);
    chk("mis_be",   32'(mem_be), 32'hF);
    ack(0, 32'h1122_3344);
    chk("mis_wbv",  32'(wb_valid), 32'd1);
    chk("mis_data", wb_data, 32'h1122_3344);
    chk("mis_rd",   32'(wb_rd), 32'd9);
    step();
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
